// File: rtl/wave_amplifier_if.sv
// ----------------------------------------------------------------------------
// wave_amplifier_if
// Handshake and data bundle for the wave_amplifier gain stage.
//   start   : request, sampled only while the stage is idle
//   inwave  : 16-bit unsigned sample, captured with start
//   n       : 3-bit left-shift amount, captured with start
//   busy    : high while the shift is in progress
//   done    : one-cycle pulse, outwave/ovf valid
//   outwave : amplified sample, held until the next result
//   ovf     : a '1' bit was shifted past bit 15
// master drives the request side; slave is the amplifier.
// ----------------------------------------------------------------------------
interface wave_amplifier_if;
   logic        start;
   logic [15:0] inwave;
   logic [2:0]  n;
   logic        busy;
   logic        done;
   logic [15:0] outwave;
   logic        ovf;

   modport master (output start, inwave, n,
                   input  busy, done, outwave, ovf);
   modport slave  (input  start, inwave, n,
                   output busy, done, outwave, ovf);
endinterface

// File: rtl/wave_amplifier.sv
// ----------------------------------------------------------------------------
// wave_amplifier
// Sequential left-shift gain stage: outwave = inwave * 2^n, n = 0..7, one bit
// per clock. Inverse of the right-shift attenuator in the waveform path.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   wa    : wave_amplifier_if.slave (start/inwave/n in, busy/done/outwave/ovf out)
// Build option:
//   SATURATE_EN : when defined, an overflowed result is clamped to 16'hFFFF;
//                 otherwise the low 16 bits are returned (wrap-around).
//                 ovf reports lost bits in both builds.
// Timing: capture edge k, shift edges k+1..k+n, result edge k+n+1,
//         next acceptance no earlier than k+n+2.
// ----------------------------------------------------------------------------
module wave_amplifier (
   input  logic              clk,
   input  logic              rst_n,
   wave_amplifier_if.slave   wa
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]  state;
   logic [15:0] acc;
   logic [2:0]  cnt;
   logic        lost;
   logic [15:0] outwave_q;
   logic        ovf_q;
   logic        done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= 16'h0000;
         cnt       <= 3'd0;
         lost      <= 1'b0;
         outwave_q <= 16'h0000;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (wa.start) begin
                  acc   <= wa.inwave;
                  cnt   <= wa.n;
                  lost  <= 1'b0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt != 3'd0) begin
                  // bit 15 leaves the register on this shift
                  lost <= lost | acc[15];
                  acc  <= {acc[14:0], 1'b0};
                  cnt  <= cnt - 3'd1;
               end else begin
`ifdef SATURATE_EN
                  outwave_q <= lost ? 16'hFFFF : acc;
`else
                  outwave_q <= acc;
`endif
                  ovf_q  <= lost;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign wa.busy    = (state == SHIFT);
   assign wa.done    = done_q;
   assign wa.outwave = outwave_q;
   assign wa.ovf     = ovf_q;

endmodule

// File: tb/tb_wave_amplifier.sv
// ----------------------------------------------------------------------------
// tb_wave_amplifier
// Scoreboard bench for wave_amplifier. The stimulus process decides, from the
// n+2 cycle occupancy rule, which start requests are accepted and queues the
// expected result (inwave<<n, arithmetic on a wide word) with the edge it is
// due on. A negedge monitor checks busy, done, outwave and ovf every cycle.
// Define SATURATE_EN for both RTL and bench to exercise the clamping build.
// ----------------------------------------------------------------------------
module tb_wave_amplifier;

   typedef struct {
      int          acc_edge;
      int          done_edge;
      logic [15:0] out;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   wave_amplifier_if wif ();

   wave_amplifier u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wa    (wif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        q[$];
   int          edge_cnt  = 0;
   int          next_free = 0;
   int          tests     = 0;
   int          errors    = 0;
   logic [15:0] held_out  = 16'h0000;
   logic        held_ovf  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Reference: multiply by 2^n in a 32-bit word, anything above bit 15 is lost.
   function automatic void model(input logic [15:0] w, input logic [2:0] s,
                                 output logic [15:0] o, output logic v);
      logic [31:0] wide;
      wide = 32'(w) * (32'd1 << s);
      v    = (wide > 32'h0000_FFFF);
      o    = wide[15:0];
`ifdef SATURATE_EN
      if (v) o = 16'hFFFF;
`endif
   endfunction

   // Advance one rising edge; record an accepted request in the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      edge_cnt++;
      if (rst_n && wif.start && edge_cnt >= next_free) begin
         e.acc_edge  = edge_cnt;
         e.done_edge = edge_cnt + int'(wif.n) + 1;
         model(wif.inwave, wif.n, e.out, e.ovf);
         q.push_back(e);
         next_free = edge_cnt + int'(wif.n) + 2;
      end
      #1;
   endtask

   task automatic drive(input logic s, input logic [15:0] w, input logic [2:0] nn);
      wif.start  = s;
      wif.inwave = w;
      wif.n      = nn;
      tick();
   endtask

   task automatic wait_idle();
      wif.start = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      tests++;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL timeout: %0d results outstanding, expected 0", q.size());
         q.delete();
      end
      tick();
   endtask

   task automatic single(input logic [15:0] w, input logic [2:0] nn);
      drive(1'b1, w, nn);
      wif.start = 1'b0;
      wait_idle();
   endtask

   // Monitor: compares every cycle against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         logic busy_exp, done_exp;
         busy_exp = q.size() > 0 && edge_cnt >= q[0].acc_edge && edge_cnt < q[0].done_edge;
         done_exp = q.size() > 0 && edge_cnt == q[0].done_edge;
         chk("busy", 32'(wif.busy), 32'(busy_exp));
         chk("done", 32'(wif.done), 32'(done_exp));
         if (done_exp) begin
            held_out = q[0].out;
            held_ovf = q[0].ovf;
            void'(q.pop_front());
         end
         chk("outwave", 32'(wif.outwave), 32'(held_out));
         chk("ovf", 32'(wif.ovf), 32'(held_ovf));
      end
   end

   initial begin
      rst_n      = 1'b0;
      wif.start  = 1'b0;
      wif.inwave = 16'h0000;
      wif.n      = 3'd0;
      tick();
      tick();
      chk("rst_busy", 32'(wif.busy), 32'd0);
      chk("rst_done", 32'(wif.done), 32'd0);
      chk("rst_outwave", 32'(wif.outwave), 32'd0);
      chk("rst_ovf", 32'(wif.ovf), 32'd0);
      rst_n = 1'b1;
      tick();

      // directed vectors
      single(16'h0123, 3'd4);
      single(16'h8001, 3'd1);
      single(16'hBEEF, 3'd0);
      single(16'h01FF, 3'd7);
      single(16'h0200, 3'd7);
      single(16'hFFFF, 3'd7);

      // busy rejection: accepted at k, pokes at k+2 and k+6, held to k+7
      drive(1'b1, 16'h0011, 3'd5);   // k
      drive(1'b0, 16'h0000, 3'd0);   // k+1
      drive(1'b1, 16'hAAAA, 3'd1);   // k+2 ignored
      drive(1'b0, 16'h0000, 3'd0);   // k+3
      drive(1'b0, 16'h0000, 3'd0);   // k+4
      drive(1'b0, 16'h0000, 3'd0);   // k+5
      drive(1'b1, 16'h5555, 3'd2);   // k+6 ignored (result edge)
      drive(1'b1, 16'h5555, 3'd2);   // k+7 accepted
      wif.start = 1'b0;
      wait_idle();

      // reset mid-operation
      drive(1'b1, 16'h1234, 3'd6);   // k
      drive(1'b0, 16'h0000, 3'd0);   // k+1
      drive(1'b0, 16'h0000, 3'd0);   // k+2
      drive(1'b0, 16'h0000, 3'd0);   // k+3
      rst_n = 1'b0;
      q.delete();
      held_out  = 16'h0000;
      held_ovf  = 1'b0;
      next_free = 0;
      #1;
      chk("abort_busy", 32'(wif.busy), 32'd0);
      chk("abort_done", 32'(wif.done), 32'd0);
      chk("abort_outwave", 32'(wif.outwave), 32'd0);
      chk("abort_ovf", 32'(wif.ovf), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      single(16'h0F0F, 3'd3);

      // back-to-back with start held high, n=2
      for (int i = 0; i < 24; i++) drive(1'b1, 16'($urandom), 3'd2);
      wait_idle();

      // random traffic, including requests and input churn while busy
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 2) == 0), 16'($urandom), 3'($urandom));
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
